// File: rtl/bp_pkg.sv
// Shared branch-prediction types: history width, queue depth and the in-flight entry layout.
// Also used by the PHT so both agree on index and history widths.
package bp_pkg;

  localparam int unsigned HIST_W = 8;
  localparam int unsigned DEPTH  = 8;

  typedef struct packed {
    logic [HIST_W-1:0] pc;
    logic [HIST_W-1:0] bhr;
    logic              pred_taken;
  } bp_entry_t;

  // Shift a new outcome into the LSB; the oldest bit falls off the top.
  function automatic logic [HIST_W-1:0] hist_shift(input logic [HIST_W-1:0] hist,
                                                   input logic              taken);
    return HIST_W'({hist, taken});
  endfunction

endpackage

// File: rtl/bp_entry_ram.sv
// Storage for in-flight predictions: one synchronous write port, one asynchronous read port.
// The array is deliberately not reset; validity is tracked by the queue pointers.
module bp_entry_ram
  import bp_pkg::*;
#(
  parameter int unsigned Depth = DEPTH,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  bp_entry_t        wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output bp_entry_t        rdata_o
);

  bp_entry_t mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of branch predictions awaiting resolution. Tracks speculative and
// architectural history, emits PHT updates and flushes younger entries on a mispredict.
module branch_resolve_queue #(
  parameter int unsigned DEPTH  = bp_pkg::DEPTH,
  parameter int unsigned HIST_W = bp_pkg::HIST_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [HIST_W-1:0]        pred_pc,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  output logic [HIST_W-1:0]        spec_bhr,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     res_ready,
  output logic                     update,
  output logic [HIST_W-1:0]        upd_bhr,
  output logic [HIST_W-1:0]        upd_pc,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   count
);

  import bp_pkg::*;

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [HIST_W-1:0] spec_bhr_q, spec_bhr_d;
  logic [HIST_W-1:0] arch_bhr_q, arch_bhr_d;
  logic              update_q, update_d;
  logic              mispredict_q, mispredict_d;
  logic [HIST_W-1:0] upd_bhr_q, upd_bhr_d;
  logic [HIST_W-1:0] upd_pc_q, upd_pc_d;
  logic              upd_taken_q, upd_taken_d;

  logic      full, empty;
  logic      enq, deq, flush;
  bp_entry_t wr_entry, rd_entry;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  assign deq   = res_valid && !empty;
  assign flush = deq && (res_taken != rd_entry.pred_taken);
  // A flush kills everything younger than the resolving branch, including this cycle's fetch.
  assign enq   = pred_valid && !full && !flush;

  assign wr_entry = '{pc: pred_pc, bhr: spec_bhr_q, pred_taken: pred_taken};

  bp_entry_ram #(
    .Depth (DEPTH),
    .AddrW (PtrW)
  ) u_entry_ram (
    .clk_i   (clk),
    .we_i    (enq),
    .waddr_i (tail_q),
    .wdata_i (wr_entry),
    .raddr_i (head_q),
    .rdata_o (rd_entry)
  );

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    spec_bhr_d   = spec_bhr_q;
    arch_bhr_d   = arch_bhr_q;
    update_d     = 1'b0;
    mispredict_d = 1'b0;
    upd_bhr_d    = upd_bhr_q;
    upd_pc_d     = upd_pc_q;
    upd_taken_d  = upd_taken_q;

    if (enq) begin
      tail_d     = tail_q + PtrW'(1);
      spec_bhr_d = hist_shift(spec_bhr_q, pred_taken);
    end

    if (deq) begin
      head_d      = head_q + PtrW'(1);
      arch_bhr_d  = hist_shift(arch_bhr_q, res_taken);
      update_d    = 1'b1;
      upd_bhr_d   = rd_entry.bhr;
      upd_pc_d    = rd_entry.pc;
      upd_taken_d = res_taken;
    end

    // Rewind speculative history to the architectural one, including this outcome.
    if (flush) begin
      tail_d       = head_q + PtrW'(1);
      spec_bhr_d   = hist_shift(arch_bhr_q, res_taken);
      mispredict_d = 1'b1;
    end

    if (flush) begin
      count_d = '0;
    end else if (enq && !deq) begin
      count_d = count_q + CntW'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      spec_bhr_q   <= '0;
      arch_bhr_q   <= '0;
      update_q     <= 1'b0;
      mispredict_q <= 1'b0;
      upd_bhr_q    <= '0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      spec_bhr_q   <= spec_bhr_d;
      arch_bhr_q   <= arch_bhr_d;
      update_q     <= update_d;
      mispredict_q <= mispredict_d;
      upd_bhr_q    <= upd_bhr_d;
      upd_pc_q     <= upd_pc_d;
      upd_taken_q  <= upd_taken_d;
    end
  end

  assign pred_ready = !full;
  assign res_ready  = !empty;
  assign spec_bhr   = spec_bhr_q;
  assign update     = update_q;
  assign mispredict = mispredict_q;
  assign upd_bhr    = upd_bhr_q;
  assign upd_pc     = upd_pc_q;
  assign upd_taken  = upd_taken_q;
  assign count      = count_q;

endmodule
